// File: rtl/cursor_edit_ctrl.sv
// Mode/cursor edit controller for the clock display; optional cursor blink under EDIT_BLINK_EN.
// Actions register in the same edge as the button pulse; wr_stb is a 1-cycle strobe with no backpressure.
module cursor_edit_ctrl #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000,
  parameter logic [31:0] BLINK_HALF     = 32'd12_500_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       btn_mode,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       ld_valid,
  input  logic [3:0] ld_addr,
  input  logic [7:0] ld_data,
  output logic       bandera_hh,
  output logic       bandera_mh,
  output logic       bandera_sh,
  output logic       bandera_df,
  output logic       bandera_mf,
  output logic       bandera_af,
  output logic       bandera_hc,
  output logic       bandera_mc,
  output logic       bandera_sc,
  output logic [1:0] edit_mode,
  output logic       wr_stb,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] field_0,
  output logic [7:0] field_1,
  output logic [7:0] field_2,
  output logic [7:0] field_3,
  output logic [7:0] field_4,
  output logic [7:0] field_5,
  output logic [7:0] field_6,
  output logic [7:0] field_7,
  output logic [7:0] field_8
);

  typedef enum logic [1:0] {RUN = 2'd0, EDIT_TIME = 2'd1, EDIT_DATE = 2'd2, EDIT_TIMER = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cur_q, cur_d;
  logic [7:0]  field_q [9];
  logic [7:0]  field_d [9];
  logic [8:0]  flag_q, flag_d;
  logic        wr_stb_q, wr_stb_d;
  logic [3:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [31:0] tmo_q, tmo_d;
  logic [3:0]  sel, sel_d;
  logic [7:0]  nv;
  logic        any_btn;
  logic        blink_on_d;

  function automatic logic [7:0] fmin(input logic [3:0] idx);
    return (idx == 4'd3 || idx == 4'd4) ? 8'd1 : 8'd0;
  endfunction

  function automatic logic [7:0] fmax(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd6: fmax = 8'd23;
      4'd3:       fmax = 8'd31;
      4'd4:       fmax = 8'd12;
      4'd5:       fmax = 8'd99;
      default:    fmax = 8'd59;
    endcase
  endfunction

  function automatic logic [3:0] base(input state_t s);
    case (s)
      EDIT_DATE:  base = 4'd3;
      EDIT_TIMER: base = 4'd6;
      default:    base = 4'd0;
    endcase
  endfunction

  assign any_btn = btn_mode | btn_left | btn_right | btn_up | btn_down;
  assign sel     = base(state_q) + {2'b00, cur_q};

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    field_d   = field_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    tmo_d     = 32'd0;
    nv        = field_q[sel];
    if (state_q == RUN) begin
      if (btn_mode) begin
        state_d = EDIT_TIME;
        cur_d   = 2'd0;
      end
      if (ld_valid && ld_addr <= 4'd8 && ld_data >= fmin(ld_addr) && ld_data <= fmax(ld_addr))
        field_d[ld_addr] = ld_data;
    end else begin
      // A button in the timeout cycle wins: the counter clears instead of expiring.
      if (!any_btn) begin
        if (tmo_q + 32'd1 >= TIMEOUT_CYCLES) begin
          state_d = RUN;
          cur_d   = 2'd0;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      if (btn_mode) begin
        cur_d = 2'd0;
        case (state_q)
          EDIT_TIME: state_d = EDIT_DATE;
          EDIT_DATE: state_d = EDIT_TIMER;
          default:   state_d = RUN;
        endcase
      end else if (btn_left || btn_right) begin
        if (btn_right && !btn_left)
          cur_d = (cur_q == 2'd2) ? 2'd0 : cur_q + 2'd1;
        else if (btn_left && !btn_right)
          cur_d = (cur_q == 2'd0) ? 2'd2 : cur_q - 2'd1;
      end else if (btn_up ^ btn_down) begin
        if (btn_up)
          nv = (field_q[sel] >= fmax(sel)) ? fmin(sel) : field_q[sel] + 8'd1;
        else
          nv = (field_q[sel] <= fmin(sel)) ? fmax(sel) : field_q[sel] - 8'd1;
        field_d[sel] = nv;
        wr_stb_d     = 1'b1;
        wr_addr_d    = sel;
        wr_data_d    = nv;
      end
    end
  end

`ifdef EDIT_BLINK_EN
  logic [31:0] blink_cnt_q, blink_cnt_d;
  logic        blink_on_q;
  logic        blink_restart;

  assign blink_restart = (state_d != state_q) || (cur_d != cur_q) || wr_stb_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + 32'd1;
    blink_on_d  = blink_on_q;
    if (state_d == RUN || blink_restart) begin
      blink_cnt_d = 32'd0;
      blink_on_d  = 1'b1;
    end else if (blink_cnt_q + 32'd1 >= BLINK_HALF) begin
      blink_cnt_d = 32'd0;
      blink_on_d  = ~blink_on_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      blink_cnt_q <= 32'd0;
      blink_on_q  <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end
`else
  logic unused_blink_half;
  assign unused_blink_half = ^BLINK_HALF;
  assign blink_on_d        = 1'b1;
`endif

  assign sel_d  = base(state_d) + {2'b00, cur_d};
  assign flag_d = (state_d == RUN || !blink_on_d) ? 9'd0 : (9'd1 << sel_d);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= RUN;
      cur_q     <= 2'd0;
      for (int i = 0; i < 9; i++) field_q[i] <= fmin(4'(i));
      flag_q    <= 9'd0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= 4'd0;
      wr_data_q <= 8'd0;
      tmo_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      field_q   <= field_d;
      flag_q    <= flag_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      tmo_q     <= tmo_d;
    end
  end

  assign {bandera_sc, bandera_mc, bandera_hc, bandera_af, bandera_mf,
          bandera_df, bandera_sh, bandera_mh, bandera_hh} = flag_q;
  assign edit_mode = state_q;
  assign wr_stb    = wr_stb_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign field_0   = field_q[0];
  assign field_1   = field_q[1];
  assign field_2   = field_q[2];
  assign field_3   = field_q[3];
  assign field_4   = field_q[4];
  assign field_5   = field_q[5];
  assign field_6   = field_q[6];
  assign field_7   = field_q[7];
  assign field_8   = field_q[8];

endmodule

// File: tb/tb_cursor_edit_ctrl.sv
// Directed bench for cursor_edit_ctrl: strobes go through an expected-write queue, state/flags checked inline.
module tb_cursor_edit_ctrl;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       btn_mode = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic       ld_valid = 1'b0;
  logic [3:0] ld_addr = 4'd0;
  logic [7:0] ld_data = 8'd0;
  logic       bandera_hh, bandera_mh, bandera_sh, bandera_df, bandera_mf;
  logic       bandera_af, bandera_hc, bandera_mc, bandera_sc;
  logic [1:0] edit_mode;
  logic       wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] field_0, field_1, field_2, field_3, field_4, field_5, field_6, field_7, field_8;
  logic [8:0] flags;

  localparam logic [4:0] MODE = 5'b10000, LEFT = 5'b01000, RIGHT = 5'b00100, UP = 5'b00010, DOWN = 5'b00001;

  typedef struct packed {logic [3:0] addr; logic [7:0] data;} wr_t;
  wr_t exp_q[$];
  int  n_pass = 0;
  int  n_total = 0;

  always #5 CLK = ~CLK;

  cursor_edit_ctrl #(.TIMEOUT_CYCLES(32'd20), .BLINK_HALF(32'd8)) dut (
    .CLK(CLK), .RESET(RESET),
    .btn_mode(btn_mode), .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .bandera_hh(bandera_hh), .bandera_mh(bandera_mh), .bandera_sh(bandera_sh),
    .bandera_df(bandera_df), .bandera_mf(bandera_mf), .bandera_af(bandera_af),
    .bandera_hc(bandera_hc), .bandera_mc(bandera_mc), .bandera_sc(bandera_sc),
    .edit_mode(edit_mode), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .field_0(field_0), .field_1(field_1), .field_2(field_2), .field_3(field_3), .field_4(field_4),
    .field_5(field_5), .field_6(field_6), .field_7(field_7), .field_8(field_8)
  );

  assign flags = {bandera_sc, bandera_mc, bandera_hc, bandera_af, bandera_mf,
                  bandera_df, bandera_sh, bandera_mh, bandera_hh};

  function automatic int fld(input int i);
    case (i)
      0: return int'(field_0);
      1: return int'(field_1);
      2: return int'(field_2);
      3: return int'(field_3);
      4: return int'(field_4);
      5: return int'(field_5);
      6: return int'(field_6);
      7: return int'(field_7);
      default: return int'(field_8);
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic press(input logic [4:0] b);
    {btn_mode, btn_left, btn_right, btn_up, btn_down} = b;
    @(posedge CLK); #1;
    {btn_mode, btn_left, btn_right, btn_up, btn_down} = 5'b0;
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    @(posedge CLK); #1;
    ld_valid = 1'b0;
  endtask

  task automatic expect_wr(input int a, input int d);
    exp_q.push_back({4'(a), 8'(d)});
  endtask

  // Monitor: every strobe must match the oldest expected write.
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge CLK);
      if (wr_stb) begin
        if (exp_q.size() == 0) chk("unexpected_wr_stb", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("wr_addr", int'(wr_addr), int'(e.addr));
          chk("wr_data", int'(wr_data), int'(e.data));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int rst_val [9];
    rst_val = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    chk("rst_edit_mode", int'(edit_mode), 0);
    chk("rst_flags", int'(flags), 0);
    chk("rst_wr_stb", int'(wr_stb), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", int'(wr_data), 0);
    for (int i = 0; i < 9; i++) chk($sformatf("rst_field_%0d", i), fld(i), rst_val[i]);

    press(MODE);
    chk("time_mode", int'(edit_mode), 1);
    chk("time_flags", int'(flags), 9'b000000001);

    expect_wr(0, 23); press(DOWN); chk("hour_dn_wrap", fld(0), 23);
    expect_wr(0, 0);  press(UP);   chk("hour_up_wrap", fld(0), 0);
    expect_wr(0, 1); expect_wr(0, 2);
    btn_up = 1'b1; @(posedge CLK); @(posedge CLK); #1 btn_up = 1'b0;
    chk("hour_b2b", fld(0), 2);

    press(RIGHT | UP);
    chk("rgt_up_flags", int'(flags), 9'b000000010);
    chk("rgt_up_hour", fld(0), 2);
    chk("rgt_up_min", fld(1), 0);
    press(LEFT | RIGHT); chk("lr_flags", int'(flags), 9'b000000010);
    press(LEFT);         chk("left_flags", int'(flags), 9'b000000001);
    press(LEFT);         chk("left_wrap", int'(flags), 9'b000000100);
    press(RIGHT);        chk("right_wrap", int'(flags), 9'b000000001);
    load(4'd2, 8'd45);   chk("load_in_edit", fld(2), 0);

    press(MODE);
    chk("date_mode", int'(edit_mode), 2);
    chk("date_flags", int'(flags), 9'b000001000);
    press(LEFT);         chk("af_flag", int'(bandera_af), 1);
    expect_wr(5, 99); press(DOWN); chk("year_wrap", fld(5), 99);
    press(RIGHT);        chk("day_flags", int'(flags), 9'b000001000);
    expect_wr(3, 31); press(DOWN); chk("day_dn_wrap", fld(3), 31);
    expect_wr(3, 1);  press(UP);   chk("day_up_wrap", fld(3), 1);
    press(RIGHT);
    chk("hold_wr_addr", int'(wr_addr), 3);
    chk("hold_wr_data", int'(wr_data), 1);
    chk("hold_wr_stb", int'(wr_stb), 0);

    press(MODE);
    chk("timer_mode", int'(edit_mode), 3);
    chk("timer_flags", int'(flags), 9'b001000000);
    press(MODE);
    chk("run_mode", int'(edit_mode), 0);
    chk("run_flags", int'(flags), 0);
    press(UP);           chk("run_up_ignored", fld(0), 2);

    load(4'd2, 8'd45);   chk("load_ok", fld(2), 45);
    load(4'd2, 8'd60);   chk("load_sec_range", fld(2), 45);
    load(4'd4, 8'd13);   chk("load_mon_range", fld(4), 1);
    load(4'd4, 8'd12);   chk("load_mon_max", fld(4), 12);
    load(4'd3, 8'd15);   chk("load_day", fld(3), 15);
    load(4'd3, 8'd0);    chk("load_day_zero", fld(3), 15);

    press(MODE); press(MODE); press(MODE);
    chk("to_enter", int'(edit_mode), 3);
    repeat (19) @(posedge CLK);
    #1 chk("to_before", int'(edit_mode), 3);
    @(posedge CLK);
    #1 chk("to_expired", int'(edit_mode), 0);
    chk("to_flags", int'(flags), 0);

    press(MODE); press(MODE); press(MODE);
    repeat (19) @(posedge CLK);
    #1 press(RIGHT);
    chk("to_btn_mode", int'(edit_mode), 3);
    chk("to_btn_flags", int'(flags), 9'b010000000);

    RESET = 1'b1; btn_up = 1'b1;
    @(posedge CLK); #1 btn_up = 1'b0;
    chk("mid_rst_mode", int'(edit_mode), 0);
    chk("mid_rst_flags", int'(flags), 0);
    chk("mid_rst_stb", int'(wr_stb), 0);
    chk("mid_rst_addr", int'(wr_addr), 0);
    chk("mid_rst_data", int'(wr_data), 0);
    chk("mid_rst_f2", fld(2), 0);
    chk("mid_rst_f4", fld(4), 1);
    chk("mid_rst_f7", fld(7), 0);
    @(posedge CLK); #1 RESET = 1'b0;

    repeat (3) @(posedge CLK);
    #1 chk("pending_writes", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
